// File: rtl/mul_sign_ctrl.sv
// rtl/mul_sign_ctrl.sv - RV32M sign/control stage around an unsigned pipelined multiplier
// Optional last-product cache enabled by MUL_SIGN_CTRL_FUSE_EN.
module mul_sign_ctrl #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        op_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [TAGW-1:0]   tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [TAGW-1:0]   tag_o,
    output logic              mul_req_o,
    output logic [XLEN-1:0]   mul_a_o,
    output logic [XLEN-1:0]   mul_b_o,
    input  logic              mul_ready_i,
    input  logic [2*XLEN-1:0] mul_result_i
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [TAGW-1:0]    r_tag;
    logic               r_neg;
    logic [XLEN-1:0]    r_mul_a;
    logic [XLEN-1:0]    r_mul_b;
    logic [XLEN-1:0]    r_result;
    logic [TAGW-1:0]    r_tag_o;
    logic               r_valid;

    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic               w_hit;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_sel;

    assign ready_o   = (r_state == S_IDLE) & rst_i;
    assign w_accept  = valid_i & ready_o & ~flush_i;
    assign w_sa      = ((op_i == OP_MULH) | (op_i == OP_MULHSU)) & rs1_i[XLEN-1];
    assign w_sb      = (op_i == OP_MULH) & rs2_i[XLEN-1];
    // Magnitude product is corrected back to two's complement when signs differ
    assign w_prod    = r_neg ? (-mul_result_i) : mul_result_i;
    assign w_sel     = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign valid_o   = r_valid;
    assign result_o  = r_result;
    assign tag_o     = r_tag_o;
    assign mul_req_o = (r_state == S_BUSY);
    assign mul_a_o   = r_mul_a;
    assign mul_b_o   = r_mul_b;

`ifdef MUL_SIGN_CTRL_FUSE_EN
    logic [2*XLEN-1:0]  r_c_p;
    logic [XLEN-1:0]    r_c_rs1;
    logic [XLEN-1:0]    r_c_rs2;
    logic [1:0]         r_c_op;
    logic               r_cvld;
    logic [XLEN-1:0]    r_rs1;
    logic [XLEN-1:0]    r_rs2;
    logic [XLEN-1:0]    w_c_sel;

    // Low half is the same for every signedness, so MUL may reuse any cached op
    assign w_hit   = r_cvld & (rs1_i == r_c_rs1) & (rs2_i == r_c_rs2)
                   & ((op_i == OP_MUL) | (op_i == r_c_op));
    assign w_c_sel = (op_i == OP_MUL) ? r_c_p[XLEN-1:0] : r_c_p[2*XLEN-1:XLEN];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_c_p   <= '0;
            r_c_rs1 <= '0;
            r_c_rs2 <= '0;
            r_c_op  <= '0;
            r_cvld  <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else if (flush_i) begin
            r_cvld  <= 1'b0;
        end else if (w_accept) begin
            r_rs1   <= rs1_i;
            r_rs2   <= rs2_i;
        end else if ((r_state == S_BUSY) && mul_ready_i) begin
            r_c_p   <= w_prod;
            r_c_rs1 <= r_rs1;
            r_c_rs2 <= r_rs2;
            r_c_op  <= r_op;
            r_cvld  <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_hit ? S_DONE : S_BUSY;
            S_BUSY: if (mul_ready_i) w_next = S_DONE;
            S_DONE: if (ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush_i) w_next = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_tag    <= '0;
            r_neg    <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_result <= '0;
            r_tag_o  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (flush_i) begin
                r_valid <= 1'b0;
                r_op    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_op    <= op_i;
                        r_tag   <= tag_i;
                        r_neg   <= w_sa ^ w_sb;
                        r_mul_a <= w_sa ? (-rs1_i) : rs1_i;
                        r_mul_b <= w_sb ? (-rs2_i) : rs2_i;
`ifdef MUL_SIGN_CTRL_FUSE_EN
                        if (w_hit) begin
                            r_result <= w_c_sel;
                            r_tag_o  <= tag_i;
                            r_valid  <= 1'b1;
                        end
`endif
                    end
                    S_BUSY: if (mul_ready_i) begin
                        r_result <= w_sel;
                        r_tag_o  <= r_tag;
                        r_valid  <= 1'b1;
                    end
                    S_DONE: if (ready_i) r_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule
